// File: rtl/fab_reset_seq_if.sv
// Reset-sequencer signal bundle: asynchronous qualifiers in, staged resets and status out.
interface fab_reset_seq_if;
    logic       LOCK_IN;
    logic       BTN_RESET_N;
    logic       CORE_RESET;
    logic       PERIPH_RESET_N;
    logic       READY;
    logic [1:0] RESET_CAUSE;
    logic [7:0] RESTART_COUNT;

    modport master (
        output LOCK_IN, BTN_RESET_N,
        input  CORE_RESET, PERIPH_RESET_N, READY, RESET_CAUSE, RESTART_COUNT
    );

    modport slave (
        input  LOCK_IN, BTN_RESET_N,
        output CORE_RESET, PERIPH_RESET_N, READY, RESET_CAUSE, RESTART_COUNT
    );
endinterface

// File: rtl/fab_reset_seq.sv
// Fabric reset sequencer: qualifies CCC lock and a debounced button, then releases
// core reset and, a fixed gap later, peripheral reset; records why it last restarted.
module fab_reset_seq #(
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGE_GAP       = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit LOCK_EN         = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic            FAB_CLK,
    input  logic            FAB_RESET,
    fab_reset_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        REL_CORE,
        RUN
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dbCnt_q, dbCnt_d;
    logic             lockMeta_q, lockSync_q;
    logic             btnMeta_q, btnSync_q;
    logic             btnDbN_q, btnDbN_d;
    logic             coreReset_q;
    logic             ready_q;
    logic [1:0]       cause_q, cause_d;
    logic [7:0]       restarts_q, restarts_d;

    logic lockOk;
    logic btnPress;
    logic abort;

    assign lockOk   = LOCK_EN ? lockSync_q : 1'b1;
    assign btnPress = ~btnDbN_q;
    assign abort    = ~lockOk | btnPress;

    // Debounced level only follows the synchronised button after a full run of
    // consecutive differing samples; any matching sample restarts the run.
    always_comb begin
        btnDbN_d = btnDbN_q;
        dbCnt_d  = '0;
        if (btnSync_q != btnDbN_q) begin
            if (dbCnt_q == DB_LAST) begin
                btnDbN_d = btnSync_q;
            end else begin
                dbCnt_d = dbCnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        restarts_d = restarts_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lockOk && !btnPress) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = REL_CORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REL_CORE: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // An abort overrides whatever terminal-count progress happened above.
        if (state_q != WAIT_LOCK && abort) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            cause_d = {btnPress, ~lockOk};
            if (restarts_q != 8'hFF) begin
                restarts_d = restarts_q + 8'd1;
            end
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            dbCnt_q     <= '0;
            lockMeta_q  <= 1'b0;
            lockSync_q  <= 1'b0;
            btnMeta_q   <= 1'b1;
            btnSync_q   <= 1'b1;
            btnDbN_q    <= 1'b1;
            coreReset_q <= 1'b1;
            ready_q     <= 1'b0;
            cause_q     <= 2'b00;
            restarts_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbCnt_q     <= dbCnt_d;
            lockMeta_q  <= bus.LOCK_IN;
            lockSync_q  <= lockMeta_q;
            btnMeta_q   <= bus.BTN_RESET_N;
            btnSync_q   <= btnMeta_q;
            btnDbN_q    <= btnDbN_d;
            coreReset_q <= (state_d == WAIT_LOCK) || (state_d == HOLD);
            ready_q     <= (state_d == RUN);
            cause_q     <= cause_d;
            restarts_q  <= restarts_d;
        end
    end

    // Peripheral release and READY are the same registered bit, so peripherals can
    // never be out of reset while the core is still held.
    assign bus.CORE_RESET     = coreReset_q;
    assign bus.PERIPH_RESET_N = ready_q;
    assign bus.READY          = ready_q;
    assign bus.RESET_CAUSE    = cause_q;
    assign bus.RESTART_COUNT  = restarts_q;

endmodule

// File: tb/tb_fab_reset_seq.sv
// Bench for fab_reset_seq: default, lock-bypass and small-parameter instances, each
// tracked by an elapsed-time reference model, plus fixed-edge vectors and corner sequences.
module tb_fab_reset_seq;

    typedef struct {
        bit         lockMeta;
        bit         lockSync;
        bit         btnMeta;
        bit         btnSync;
        bit         pressed;
        int         dbRun;
        bit         armed;
        int         elapsed;
        logic [1:0] cause;
        int         restarts;
    } model_t;

    typedef struct {
        int         dutSel;
        int         edgeNum;
        logic [12:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rstSmall;
    int   compared   = 0;
    int   mismatched = 0;
    bit   checkEn    = 1'b0;
    bit   smallEn    = 1'b0;
    bit   smallDone  = 1'b0;

    model_t mDef, mNl, mSm;
    logic [12:0] obsDef, obsNl, obsSm;

    fab_reset_seq_if busDef ();
    fab_reset_seq_if busNl ();
    fab_reset_seq_if busSm ();

    fab_reset_seq dut (
        .FAB_CLK   (clk),
        .FAB_RESET (rst),
        .bus       (busDef)
    );

    fab_reset_seq #(.LOCK_EN(1'b0)) dutNoLock (
        .FAB_CLK   (clk),
        .FAB_RESET (rst),
        .bus       (busNl)
    );

    fab_reset_seq #(.HOLD_CYCLES(5), .STAGE_GAP(2), .DEBOUNCE_CYCLES(3), .CNT_W(3)) dutSmall (
        .FAB_CLK   (clk),
        .FAB_RESET (rstSmall),
        .bus       (busSm)
    );

    always #5 clk = ~clk;

    assign obsDef = {busDef.CORE_RESET, busDef.PERIPH_RESET_N, busDef.READY, busDef.RESET_CAUSE, busDef.RESTART_COUNT};
    assign obsNl  = {busNl.CORE_RESET, busNl.PERIPH_RESET_N, busNl.READY, busNl.RESET_CAUSE, busNl.RESTART_COUNT};
    assign obsSm  = {busSm.CORE_RESET, busSm.PERIPH_RESET_N, busSm.READY, busSm.RESET_CAUSE, busSm.RESTART_COUNT};

    function automatic logic [12:0] pack(bit core, bit ready, logic [1:0] cause, int restarts);
        return {core, ready, ready, cause, 8'(restarts)};
    endfunction

    // Sequencing is one elapsed count since HOLD entry: core releases after H cycles,
    // peripherals after H+G; losing qualification at any point disarms it.
    function automatic model_t modelStep(model_t m, bit reset, bit lockIn, bit btnIn,
                                         int h, int g, int d, bit lockEn);
        model_t n;
        bit lockOk;
        n = m;
        if (reset) begin
            n = '{lockMeta: 0, lockSync: 0, btnMeta: 1, btnSync: 1, pressed: 0, dbRun: 0,
                  armed: 0, elapsed: 0, cause: 2'b00, restarts: 0};
            return n;
        end
        lockOk = lockEn ? m.lockSync : 1'b1;
        if (!m.armed) begin
            if (lockOk && !m.pressed) begin
                n.armed   = 1;
                n.elapsed = 0;
            end
        end else if (!lockOk || m.pressed) begin
            n.armed = 0;
            n.cause = {m.pressed, !lockOk};
            if (m.restarts < 255) n.restarts = m.restarts + 1;
        end else if (m.elapsed < h + g) begin
            n.elapsed = m.elapsed + 1;
        end
        if (m.btnSync == !m.pressed) begin
            n.dbRun = 0;
        end else if (m.dbRun >= d - 1) begin
            n.pressed = !m.pressed;
            n.dbRun   = 0;
        end else begin
            n.dbRun = m.dbRun + 1;
        end
        n.lockMeta = lockIn;
        n.lockSync = m.lockMeta;
        n.btnMeta  = btnIn;
        n.btnSync  = m.btnMeta;
        return n;
    endfunction

    function automatic logic [12:0] modelOut(model_t m, int h, int g);
        return pack(!m.armed || m.elapsed < h, m.armed && m.elapsed >= h + g, m.cause, m.restarts);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit lockIn, input bit btnIn);
        busDef.LOCK_IN     = lockIn;
        busDef.BTN_RESET_N = btnIn;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        mDef = modelStep(mDef, rst, busDef.LOCK_IN, busDef.BTN_RESET_N, 1024, 8, 16, 1'b1);
        mNl  = modelStep(mNl, rst, busNl.LOCK_IN, busNl.BTN_RESET_N, 1024, 8, 16, 1'b0);
        mSm  = modelStep(mSm, rstSmall, busSm.LOCK_IN, busSm.BTN_RESET_N, 5, 2, 3, 1'b1);
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_default", 32'(obsDef), 32'(modelOut(mDef, 1024, 8)));
            checkOutput("model_nolock", 32'(obsNl), 32'(modelOut(mNl, 1024, 8)));
        end
        if (smallEn) begin
            checkOutput("model_small", 32'(obsSm), 32'(modelOut(mSm, 5, 2)));
        end
    end

    // Small instance: random lock, bouncy button and occasional resets.
    initial begin
        rstSmall          = 1'b1;
        busSm.LOCK_IN     = 1'b1;
        busSm.BTN_RESET_N = 1'b1;
        tick(3);
        smallEn = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            rstSmall = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) busSm.LOCK_IN = ~busSm.LOCK_IN;
            if ($urandom_range(0, 7) == 0) busSm.BTN_RESET_N = ~busSm.BTN_RESET_N;
            tick(1);
        end
        smallDone = 1'b1;
    end

    initial begin
        vec_t vecs[$];
        int   waited;

        vecs.push_back('{0, 3,    pack(1, 0, 2'b00, 0)});
        vecs.push_back('{0, 1026, pack(1, 0, 2'b00, 0)});
        vecs.push_back('{0, 1027, pack(0, 0, 2'b00, 0)});
        vecs.push_back('{0, 1034, pack(0, 0, 2'b00, 0)});
        vecs.push_back('{0, 1035, pack(0, 1, 2'b00, 0)});
        vecs.push_back('{1, 1,    pack(1, 0, 2'b00, 0)});
        vecs.push_back('{1, 1024, pack(1, 0, 2'b00, 0)});
        vecs.push_back('{1, 1025, pack(0, 0, 2'b00, 0)});
        vecs.push_back('{1, 1032, pack(0, 0, 2'b00, 0)});
        vecs.push_back('{1, 1033, pack(0, 1, 2'b00, 0)});

        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        busNl.LOCK_IN     = 1'b0;
        busNl.BTN_RESET_N = 1'b1;
        tick(5);
        checkEn = 1'b1;
        checkOutput("reset_state", 32'(obsDef), 32'(pack(1, 0, 2'b00, 0)));
        rst = 1'b0;

        for (int c = 1; c <= 1035; c++) begin
            tick(1);
            foreach (vecs[k]) begin
                if (vecs[k].edgeNum == c) begin
                    if (vecs[k].dutSel == 0)
                        checkOutput($sformatf("poweron_E%0d", c), 32'(obsDef), 32'(vecs[k].expected));
                    else
                        checkOutput($sformatf("nolock_E%0d", c), 32'(obsNl), 32'(vecs[k].expected));
                end
            end
        end

        // Lock loss in RUN, then a full re-sequence.
        tick(965);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        checkOutput("lockdrop_pending", 32'(obsDef), 32'(pack(0, 1, 2'b00, 0)));
        tick(1);
        checkOutput("lockdrop_abort", 32'(obsDef), 32'(pack(1, 0, 2'b01, 1)));
        applyStimulus(1'b1, 1'b1);
        tick(1026);
        checkOutput("reseq_core_held", 32'(obsDef), 32'(pack(1, 0, 2'b01, 1)));
        tick(1);
        checkOutput("reseq_core_rel", 32'(obsDef), 32'(pack(0, 0, 2'b01, 1)));
        tick(7);
        checkOutput("reseq_periph_held", 32'(obsDef), 32'(pack(0, 0, 2'b01, 1)));
        tick(1);
        checkOutput("reseq_periph_rel", 32'(obsDef), 32'(pack(0, 1, 2'b01, 1)));

        // Bouncing button must not abort.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, i[0]);
            for (int j = 0; j < 5; j++) begin
                tick(1);
                checkOutput("bounce_no_abort", 32'(obsDef), 32'(pack(0, 1, 2'b01, 1)));
            end
        end

        // Held press: debounced after 16 stable samples, abort the edge after.
        applyStimulus(1'b1, 1'b0);
        tick(18);
        checkOutput("press_pre_abort", 32'(obsDef), 32'(pack(0, 1, 2'b01, 1)));
        tick(1);
        checkOutput("press_abort", 32'(obsDef), 32'(pack(1, 0, 2'b10, 2)));
        for (int i = 0; i < 21; i++) begin
            tick(1);
            checkOutput("press_held_wait", 32'(obsDef), 32'(pack(1, 0, 2'b10, 2)));
        end

        // Release, settle into HOLD, then lock loss and debounced press together.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick(1);
            checkOutput("hold_core_held", 32'(busDef.CORE_RESET), 32'd1);
        end
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            checkOutput("simul_core_held", 32'(busDef.CORE_RESET), 32'd1);
        end
        applyStimulus(1'b0, 1'b0);
        tick(2);
        checkOutput("simul_pre_abort", 32'(obsDef), 32'(pack(1, 0, 2'b10, 2)));
        tick(1);
        checkOutput("simul_abort", 32'(obsDef), 32'(pack(1, 0, 2'b11, 3)));

        // Reach REL_CORE again, then assert FAB_RESET mid-sequence.
        applyStimulus(1'b1, 1'b1);
        waited = 0;
        while (busDef.CORE_RESET !== 1'b0 && waited < 3000) begin
            tick(1);
            waited++;
        end
        checkOutput("relcore_reached", 32'(waited < 3000), 32'd1);
        tick(2);
        checkOutput("relcore_state", 32'(obsDef), 32'(pack(0, 0, 2'b11, 3)));
        rst = 1'b1;
        tick(1);
        checkOutput("midseq_reset", 32'(obsDef), 32'(pack(1, 0, 2'b00, 0)));

        // Repeated lock-loss aborts from HOLD until the count saturates.
        applyStimulus(1'b0, 1'b1);
        rst = 1'b0;
        tick(3);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1);
            tick(3);
            applyStimulus(1'b0, 1'b1);
            tick(3);
            if (i == 254)
                checkOutput("count_reaches_255", 32'(busDef.RESTART_COUNT), 32'd255);
        end
        checkOutput("count_saturated", 32'(obsDef), 32'(pack(1, 0, 2'b01, 255)));

        waited = 0;
        while (!smallDone && waited < 20000) begin
            tick(1);
            waited++;
        end
        checkOutput("random_done", 32'(smallDone), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
